// File: rtl/uart_tx_out.sv
// ============================================================================
//  Module   : uart_tx_out
//  Brief    : 8N1 serial transmitter for the CPU OUT port. The UART_TX_PARITY_EN
//             macro inserts an even-parity bit, giving an 8E1 frame.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_out #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       send,
   output logic       busy,
   output logic       done,
   output logic       tx
);

   localparam int            c_BW        = $clog2(CLKS_PER_BIT);
   localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      S_PARITY = 3'd3,
`endif
      S_STOP   = 3'd4
   } state_t;

   state_t          r_state,   w_state;
   logic [7:0]      r_shreg,   w_shreg;
   logic [2:0]      r_bitcnt,  w_bitcnt;
   logic [c_BW-1:0] r_baudcnt, w_baudcnt;
   logic            w_tx, w_busy, w_done;
   logic            w_wrap;
`ifdef UART_TX_PARITY_EN
   logic            r_par, w_par;
`endif

   assign w_wrap = (r_baudcnt == c_BAUD_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_shreg   <= 8'h00;
         r_bitcnt  <= 3'd0;
         r_baudcnt <= '0;
`ifdef UART_TX_PARITY_EN
         r_par     <= 1'b0;
`endif
         tx        <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_shreg   <= w_shreg;
         r_bitcnt  <= w_bitcnt;
         r_baudcnt <= w_baudcnt;
`ifdef UART_TX_PARITY_EN
         r_par     <= w_par;
`endif
         tx        <= w_tx;
         busy      <= w_busy;
         done      <= w_done;
      end
   end

   always_comb begin
      w_state   = r_state;
      w_shreg   = r_shreg;
      w_bitcnt  = r_bitcnt;
      w_baudcnt = w_wrap ? '0 : r_baudcnt + c_BW'(1);
      w_done    = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par     = r_par;
`endif
      case (r_state)
         S_IDLE: begin
            w_baudcnt = '0;
            if (send) begin
               w_shreg  = data;
               w_bitcnt = 3'd0;
`ifdef UART_TX_PARITY_EN
               w_par    = 1'b0;
`endif
               w_state  = S_START;
            end
         end
         S_START: if (w_wrap) w_state = S_DATA;
         S_DATA: begin
            if (w_wrap) begin
               w_shreg  = {1'b0, r_shreg[7:1]};
               w_bitcnt = r_bitcnt + 3'd1;
`ifdef UART_TX_PARITY_EN
               w_par    = r_par ^ r_shreg[0];
               if (r_bitcnt == 3'd7) w_state = S_PARITY;
`else
               if (r_bitcnt == 3'd7) w_state = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: if (w_wrap) w_state = S_STOP;
`endif
         S_STOP: begin
            if (w_wrap) begin
               w_state = S_IDLE;
               w_done  = 1'b1;
            end
         end
         default: w_state = S_IDLE;
      endcase

      // Line level is decoded from the next state so tx stays a clean flop output.
      case (w_state)
         S_START:  w_tx = 1'b0;
         S_DATA:   w_tx = w_shreg[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: w_tx = w_par;
`endif
         default:  w_tx = 1'b1;
      endcase
      w_busy = (w_state != S_IDLE);
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_out.sv
// ============================================================================
//  Module   : tb_uart_tx_out
//  Brief    : Scoreboard bench for uart_tx_out with directed frames.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_out;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int F = NB * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] data = 8'h00;
   logic       send = 1'b0;
   logic       busy, done, tx;

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   logic [7:0] exp_q[$];

   logic       m_act = 1'b0;
   int         m_cyc = 0;
   int         m_bcnt = 0;
   logic [7:0] m_byte = 8'h00;
   logic       m_par = 1'b0;

   uart_tx_out #(.CLKS_PER_BIT(CPB)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .data (data),
      .send (send),
      .busy (busy),
      .done (done),
      .tx   (tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Monitor: decodes frames from tx and checks busy/done framing.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_act  = 1'b0;
         m_bcnt = 0;
      end else begin
         if (busy === 1'b1) m_bcnt++;
         else if (m_bcnt != 0) begin
            chk("busy_len", m_bcnt, F);
            chk("done_at_busy_fall", int'(done), 1);
            m_bcnt = 0;
         end
         if (done === 1'b1) begin
            done_cnt++;
            chk("done_while_busy", int'(busy), 0);
         end
         if (!m_act) begin
            if (tx === 1'b0) begin
               m_act = 1'b1;
               m_cyc = 0;
            end
         end else m_cyc++;
         if (m_act && (m_cyc % CPB) == 2) begin
            if (m_cyc / CPB == 0) chk("start_bit", int'(tx), 0);
            else if (m_cyc / CPB <= 8) m_byte[m_cyc / CPB - 1] = tx;
            else if (NB == 11 && m_cyc / CPB == 9) m_par = tx;
            else begin
               chk("stop_bit", int'(tx), 1);
               if (exp_q.size() == 0) chk("unexpected_frame", int'(m_byte), -1);
               else begin
                  logic [7:0] e;
                  e = exp_q.pop_front();
                  chk("frame_byte", int'(m_byte), int'(e));
                  if (NB == 11) chk("frame_parity", int'(m_par), int'(^e));
               end
               m_act = 1'b0;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      data = b;
      send = 1'b1;
      exp_q.push_back(b);
      @(posedge clk); #1;
      send = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_done_seen"}, int'(done === 1'b1), 1);
   endtask

   initial begin
      int bad;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad = 1;
      end
      chk("idle_quiet", bad, 0);

      send_byte(8'h55);
      wait_done("single55");

      // Second strobe lands mid-frame and must be dropped.
      send_byte(8'hA3);
      repeat (8) @(posedge clk);
      #1 data = 8'hFF; send = 1'b1;
      @(posedge clk); #1 send = 1'b0;
      wait_done("ignoreA3");

      @(posedge clk); #1;
      data = 8'h01;
      send = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(8'h01);
      data = 8'h80;
      wait_done("b2b_first");
      exp_q.push_back(8'h80);
      @(posedge clk); #1 send = 1'b0;
      @(negedge clk);
      chk("b2b_busy_nogap", int'(busy), 1);
      chk("b2b_tx_nogap", int'(tx), 0);
      wait_done("b2b_second");

      send_byte(8'h00);
      repeat (14) @(posedge clk);
      @(negedge clk); #2;
      chk("mid_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", int'(tx), 1);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_done", int'(done), 0);
      void'(exp_q.pop_front());
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      send_byte(8'h3C);
      wait_done("after_rst3C");

      send_byte(8'h07);
      wait_done("byte07");
`ifdef UART_TX_PARITY_EN
      chk("parity_07", int'(m_par), 1);
`endif

      repeat (5) @(negedge clk);
      chk("queue_empty", exp_q.size(), 0);
      chk("done_count", done_cnt, 6);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_tx_out.md
# uart_tx_out

Serial transmitter for the CPU output port. When the controller asserts OI during an OUT instruction, the block latches the bus byte and shifts it out as an 8N1 asynchronous serial frame on `tx`. `busy` lets the CPU stall its clock until the frame has left, so OUT blocks until the transfer completes. The block sits beside the result register, on the same `clk` as the CPU registers.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is 2 to 65535.
- `clk`  input  1  rising-edge system clock; same clock as the CPU registers.
- `rst_n`  input  1  asynchronous reset, active-low.
- `data`  input  8  byte to send, taken from the CPU bus. Sampled only on an accepted `send`.
- `send`  input  1  request strobe (driven by OI). Accepted only when `busy`=0.
- `busy`  output  1  high while a frame is in flight; used to hold the CPU clock.
- `done`  output  1  one-cycle pulse when the stop bit finishes.
- `tx`  output  1  serial line; idles high.

## Operation
- States: IDLE, START, DATA, PARITY (present only with the macro), STOP.
- Registers:
  - `shreg[7:0]` holds the byte being shifted.
  - `bitcnt[2:0]` counts data bits.
  - `baudcnt` is $clog2(CLKS_PER_BIT) bits wide.
  - `par` holds the running parity.
- IDLE:
  - `tx`=1, `busy`=0.
  - On `send`=1: load `shreg`←`data`, `baudcnt`←0, `bitcnt`←0, `par`←0, then go to START.
- Every non-IDLE state holds its `tx` level for exactly CLKS_PER_BIT cycles. `baudcnt` counts 0..CLKS_PER_BIT-1, and the state advances on the wrap.
- START: `tx`=0.
- DATA:
  - `tx`=`shreg[0]`.
  - On each wrap: shift `shreg` right, set `par`^=`shreg[0]`, increment `bitcnt`.
  - After the 8th bit (`bitcnt` wraps 7→0), go to PARITY or STOP.
- Bit order is LSB first.
- PARITY: `tx`=`par`, which gives even parity.
- STOP:
  - `tx`=1.
  - On the wrap, go to IDLE and pulse `done`.
- `send` while `busy`=1 is ignored. There is no queue, and `data` is not resampled.
- The transmitted byte is always the value latched at acceptance; later bus changes have no effect.
- `busy` is registered and is high in every non-IDLE state.
- Reset values: `tx`=1, `busy`=0, `done`=0, state=IDLE, `shreg`=0, `bitcnt`=0, `baudcnt`=0, `par`=0.
- Reset mid-frame: the frame is abandoned immediately. `tx` returns to 1 asynchronously and no `done` is issued.

## Timing
- `send` is sampled at edge N.
- `tx` falls and `busy` rises after edge N, both registered outputs.
- The start bit occupies cycles N+1 .. N+CLKS_PER_BIT.
- Frame length F = 10×CLKS_PER_BIT cycles without parity, 11×CLKS_PER_BIT with parity.
- `done`=1 and `busy`=0 during the cycle after edge N+F.
- A `send` asserted in that same cycle is accepted at the next edge. Back-to-back frames therefore have zero idle bit-time between the stop bit and the next start bit.
- `done` is never high while `busy`=1.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: adds the PARITY state, which sends one even-parity bit between the data bits and the stop bit. The frame is 11 bit-times.
  - Undefined: no PARITY state and no `par` register. The frame is 8N1, 10 bit-times.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release. Expect `tx`=1, `busy`=0, `done`=0, with no toggling for 50 cycles.
- Single frame: CLKS_PER_BIT=4, `data`=0x55, one-cycle `send`.
  - Expect the `tx` bit sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles.
  - Expect `busy` high for 40 cycles and `done` pulsing once at cycle 41.
- Ignore while busy: start 0xA3, then pulse `send` with `data`=0xFF at cycle 10. Expect the frame to decode as 0xA3 and only one `done`.
- Back-to-back: hold `send`=1 with 0x01 then 0x80, and apply the second `send` in the `done` cycle. Expect two frames with no idle gap, decoding as 0x01 then 0x80.
- Reset mid-frame: assert `rst_n`=0 at cycle 15 of a 0x00 frame.
  - Expect `tx`=1 and `busy`=0 immediately, and no `done`.
  - The next `send` of 0x3C transmits correctly.
- Parity (`UART_TX_PARITY_EN`): with CLKS_PER_BIT=4, send 0x07. Expect the parity bit to be 1, `busy` high for 44 cycles, and `done` at cycle 45.
